// File: rtl/chunked_seq_adder_if.sv
// Operand/result handshake bundle for chunked_seq_adder.
//   slave  : adder side  (accepts x/y/cin/sub, produces s/cout/ovf/zero)
//   master : client side (drives operands, consumes results)
interface chunked_seq_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport slave (
      input  in_valid, x, y, cin, sub, out_ready,
      output in_ready, out_valid, s, cout, ovf, zero
   );

   modport master (
      output in_valid, x, y, cin, sub, out_ready,
      input  in_ready, out_valid, s, cout, ovf, zero
   );
endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: a WIDTH-bit sum is built CHUNK bits per
// clock, least significant slice first, so only a CHUNK-bit carry chain
// sits between registers.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : operand/result handshakes (slave modport)
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operation
// RUN   | adding slice k_q each cycle
// DONE  | out_valid=1, holding results until out_ready
module chunked_seq_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   chunked_seq_adder_if.slave  bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
   logic             c_slice, c_msb, last;
   int               base;

   always_comb begin
      base = int'(k_q) * CHUNK;
      a_sl = a_q[base +: CHUNK];
      b_sl = b_q[base +: CHUNK];
      {c_slice, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
      // Carry into the top bit of this slice, recovered from the sum bit;
      // for CHUNK=1 this collapses to carry_q.
      c_msb = sum_sl[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
      last  = (k_q == KW'(NCHUNK - 1));
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.x;
               b_d     = bus.sub ? ~bus.y : bus.y;
               carry_d = bus.sub ? 1'b1 : bus.cin;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[base +: CHUNK] = sum_sl;
            carry_d = c_slice;
            k_d     = k_q + KW'(1);
            if (last) begin
               k_d     = '0;
               state_d = DONE;
               s_d     = acc_d;
               cout_d  = c_slice;
               ovf_d   = c_slice ^ c_msb;
               zero_d  = (acc_d == '0);
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.s         = s_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_chunked_seq_adder.sv
module tb_chunked_seq_adder;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 0: WIDTH=4 CHUNK=1, 1: WIDTH=16 CHUNK=4, 2: WIDTH=16 CHUNK=16
   int          sel;
   logic        in_valid, cin, sub, out_ready;
   logic [15:0] x, y;

   chunked_seq_adder_if #(.WIDTH(4))  i4  ();
   chunked_seq_adder_if #(.WIDTH(16)) i16 ();
   chunked_seq_adder_if #(.WIDTH(16)) i16c ();

   assign i4.in_valid   = in_valid && (sel == 0);
   assign i16.in_valid  = in_valid && (sel == 1);
   assign i16c.in_valid = in_valid && (sel == 2);
   assign i4.x = x[3:0];   assign i4.y = y[3:0];
   assign i16.x = x;       assign i16.y = y;
   assign i16c.x = x;      assign i16c.y = y;
   assign i4.cin = cin;    assign i16.cin = cin;   assign i16c.cin = cin;
   assign i4.sub = sub;    assign i16.sub = sub;   assign i16c.sub = sub;
   assign i4.out_ready = out_ready;
   assign i16.out_ready = out_ready;
   assign i16c.out_ready = out_ready;

   chunked_seq_adder #(.WIDTH(4),  .CHUNK(1))  u_d4  (.clk(clk), .rst_n(rst_n), .bus(i4));
   chunked_seq_adder #(.WIDTH(16), .CHUNK(4))  u_d16 (.clk(clk), .rst_n(rst_n), .bus(i16));
   chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) u_d16c(.clk(clk), .rst_n(rst_n), .bus(i16c));

   logic [15:0] s_m;
   logic        in_ready_m, out_valid_m, cout_m, ovf_m, zero_m;
   always_comb begin
      case (sel)
         0: begin
            s_m = {12'h000, i4.s}; in_ready_m = i4.in_ready; out_valid_m = i4.out_valid;
            cout_m = i4.cout; ovf_m = i4.ovf; zero_m = i4.zero;
         end
         1: begin
            s_m = i16.s; in_ready_m = i16.in_ready; out_valid_m = i16.out_valid;
            cout_m = i16.cout; ovf_m = i16.ovf; zero_m = i16.zero;
         end
         default: begin
            s_m = i16c.s; in_ready_m = i16c.in_ready; out_valid_m = i16c.out_valid;
            cout_m = i16c.cout; ovf_m = i16c.ovf; zero_m = i16c.zero;
         end
      endcase
   end

   typedef struct {
      int          d;
      logic [15:0] x, y;
      logic        cin, sub;
      logic [15:0] s;
      logic        cout, ovf, zero;
   } vec_t;

   vec_t q[$];
   vec_t tbl[12];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic int nchunk(input int d);
      return (d == 2) ? 1 : 4;
   endfunction

   function automatic vec_t mk(input int d, input logic [15:0] a, input logic [15:0] b,
                               input logic ci, input logic sb, input logic [15:0] r,
                               input logic co, input logic ov, input logic z);
      vec_t v;
      v.d = d; v.x = a; v.y = b; v.cin = ci; v.sub = sb;
      v.s = r; v.cout = co; v.ovf = ov; v.zero = z;
      return v;
   endfunction

   // Called at a negedge with the selected DUT idle; out_ready assumed high.
   task automatic run_op(input vec_t e);
      vec_t got;
      int   n;
      sel = e.d; x = e.x; y = e.y; cin = e.cin; sub = e.sub; in_valid = 1'b1;
      q.push_back(e);
      chk("in_ready_idle", in_ready_m, 1);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      chk("in_ready_busy", in_ready_m, 0);
      n = 0;
      while (!out_valid_m && n < 40) begin @(negedge clk); n++; end
      chk("latency", n, nchunk(e.d));
      got = q.pop_front();
      chk("s", s_m, got.s);
      chk("cout", cout_m, got.cout);
      chk("ovf", ovf_m, got.ovf);
      chk("zero", zero_m, got.zero);
      @(negedge clk);
      chk("back_to_idle", {out_valid_m, in_ready_m}, 2'b01);
   endtask

   initial begin
      logic [15:0] s_hold;
      logic        seen;
      int          n;

      tbl[0]  = mk(0, 16'hD, 16'h4, 0, 0, 16'h1, 1, 0, 0);
      tbl[1]  = mk(0, 16'h7, 16'h2, 0, 0, 16'h9, 0, 1, 0);
      tbl[2]  = mk(0, 16'h9, 16'hF, 0, 0, 16'h8, 1, 0, 0);
      tbl[3]  = mk(0, 16'hF, 16'h9, 0, 0, 16'h8, 1, 0, 0);
      tbl[4]  = mk(0, 16'h7, 16'h0, 1, 0, 16'h8, 0, 1, 0);
      tbl[5]  = mk(1, 16'h1234, 16'h0FCC, 0, 0, 16'h2200, 0, 0, 0);
      tbl[6]  = mk(1, 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0, 1);
      tbl[7]  = mk(1, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
      tbl[8]  = mk(1, 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 0);
      tbl[9]  = mk(1, 16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1, 0);
      tbl[10] = mk(2, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
      tbl[11] = mk(2, 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0);

      // Reset with in_valid asserted
      sel = 1; x = 16'h1234; y = 16'h0FCC; cin = 0; sub = 0;
      in_valid = 1'b1; out_ready = 1'b1; rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rst_in_ready", in_ready_m, 1);
      chk("rst_out_valid", out_valid_m, 0);
      @(posedge clk); @(negedge clk);
      chk("rst_s", s_m, 0);
      chk("rst_flags", {cout_m, ovf_m, zero_m}, 3'b000);
      in_valid = 1'b0; rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin @(negedge clk); seen |= out_valid_m; end
      chk("rst_no_accept", seen, 0);

      // Reset at the second RUN edge abandons the operation
      in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("midrst_idle", {out_valid_m, in_ready_m}, 2'b01);
      chk("midrst_s", s_m, 0);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin @(negedge clk); seen |= out_valid_m; end
      chk("midrst_no_valid", seen, 0);

      // Vector table
      for (int i = 0; i < 12; i++) run_op(tbl[i]);

      // Backpressure
      sel = 1; x = 16'h1234; y = 16'h1234; cin = 0; sub = 1; in_valid = 1'b1;
      out_ready = 1'b0;
      q.push_back(mk(1, 16'h1234, 16'h1234, 0, 1, 16'h0000, 1, 0, 1));
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid_m && n < 40) begin @(negedge clk); n++; end
      chk("bp_latency", n, 4);
      begin
         vec_t g;
         g = q.pop_front();
         chk("bp_s", s_m, g.s);
         chk("bp_flags", {cout_m, ovf_m, zero_m}, {g.cout, g.ovf, g.zero});
      end
      s_hold = s_m;
      seen = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid; x = x + 16'h0101; y = y ^ 16'hFFFF;
         @(posedge clk); @(negedge clk);
         seen &= out_valid_m & ~in_ready_m & (s_m == s_hold) & cout_m & ~ovf_m & zero_m;
      end
      chk("bp_hold", seen, 1);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("bp_release", {out_valid_m, in_ready_m}, 2'b01);
      run_op(mk(1, 16'h0001, 16'h0001, 1, 0, 16'h0003, 0, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
